// File: rtl/signed_mult_seq_if.sv
// Request/response bus of the sequential signed multiplier.
// When SIGNED_MULT_MAC_EN is defined, the bus also carries acc_clr.
interface signed_mult_seq_if #(
    parameter int unsigned WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
`ifdef SIGNED_MULT_MAC_EN
    logic                 acc_clr;
`endif
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   p;

    // Requester side (ALU opcode decoder)
    modport master (
`ifdef SIGNED_MULT_MAC_EN
        output acc_clr,
`endif
        output start, x, y,
        input  busy, done, p
    );

    // Multiplier side
    modport slave (
`ifdef SIGNED_MULT_MAC_EN
        input  acc_clr,
`endif
        input  start, x, y,
        output busy, done, p
    );
endinterface

// File: rtl/signed_mult_seq.sv
// Sequential WIDTH x WIDTH two's-complement multiplier.
// It performs one shift-and-add per clock through a single 2*WIDTH-bit adder.
// The sign-bit step subtracts instead of adding, so the product is correct
// for every operand pair, including most-negative x most-negative.
// Optional macro SIGNED_MULT_MAC_EN turns the block into a multiply-accumulate
// unit: the accumulator carries over between operations unless acc_clr is set.
module signed_mult_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    signed_mult_seq_if.slave  bus
);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_step;
    logic [PW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [PW-1:0]      r_acc;
    logic [PW-1:0]      r_p;
    logic               r_busy;
    logic               r_done;

    logic [PW-1:0]      w_shifted;
    logic [PW-1:0]      w_operand;
    logic [PW-1:0]      w_sum;
    logic               w_bit;
    logic               w_sub;
    logic               w_cin;

    // Single adder path: add the shifted multiplicand, or subtract it on the sign-bit step via ~op + 1
    always_comb begin
        w_shifted = r_mcand << r_step;
        w_bit     = r_mplier[r_step];
        w_sub     = (r_step == LAST_STEP);
        w_operand = '0;
        w_cin     = 1'b0;
        if (w_bit) begin
            w_operand = w_sub ? ~w_shifted : w_shifted;
            w_cin     = w_sub;
        end
        w_sum = r_acc + w_operand + PW'(w_cin);
    end

    // Control FSM with registered handshake outputs and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_step   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_p      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_mcand  <= {{WIDTH{bus.x[WIDTH-1]}}, bus.x};
                        r_mplier <= bus.y;
                        r_step   <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
`ifdef SIGNED_MULT_MAC_EN
                        if (bus.acc_clr) begin
                            r_acc <= '0;
                        end
`else
                        r_acc    <= '0;
`endif
                    end
                end
                S_RUN: begin
                    r_acc  <= w_sum;
                    r_step <= r_step + CNT_W'(1);
                    if (r_step == LAST_STEP) begin
                        r_p     <= w_sum;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.p    = r_p;

endmodule
